// File: rtl/armv4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : armv4_pkg
// Description : Shared types and constants for the ARMv4-subset multicycle
//               controller: FSM states, ALU op codes, instruction field
//               values and NZCV flag bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package armv4_pkg;

    // Controller states; codes 10-15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXECR  = 4'd6,
        ST_EXECI  = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9
    } state_t;

    // ALU operation select codes (upper three only exist with 8 ops).
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;
    localparam logic [2:0] ALU_MOV = 3'd5;
    localparam logic [2:0] ALU_BIC = 3'd6;

    // Instruction class field Instr[27:26].
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    // Data-processing cmd field Instr[24:21].
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_BIC = 4'b1110;

    // Bit positions inside the NZCV vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/armv4_mc_controller_cond_check.sv
`default_nettype none
// ============================================================================
// Module      : armv4_cond_check
// Description : Combinational ARMv4 condition-code evaluator. Code 1111 (NV)
//               always evaluates false.
// Revision    : 1.0 - initial release
// ============================================================================
module armv4_cond_check
    import armv4_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic w_n, w_z, w_c, w_v, w_ge;

    assign w_n  = flags[FLAG_N];
    assign w_z  = flags[FLAG_Z];
    assign w_c  = flags[FLAG_C];
    assign w_v  = flags[FLAG_V];
    assign w_ge = (w_n == w_v);

    // Decode the condition field against the registered flags.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = w_z;
            4'b0001: cond_ex = ~w_z;
            4'b0010: cond_ex = w_c;
            4'b0011: cond_ex = ~w_c;
            4'b0100: cond_ex = w_n;
            4'b0101: cond_ex = ~w_n;
            4'b0110: cond_ex = w_v;
            4'b0111: cond_ex = ~w_v;
            4'b1000: cond_ex = w_c & ~w_z;
            4'b1001: cond_ex = ~w_c | w_z;
            4'b1010: cond_ex = w_ge;
            4'b1011: cond_ex = ~w_ge;
            4'b1100: cond_ex = ~w_z & w_ge;
            4'b1101: cond_ex = w_z | ~w_ge;
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/armv4_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : armv4_mc_controller
// Description : Moore-FSM multicycle control unit for the ARMv4-subset core.
//               Drives the shared instruction/data memory datapath, holds the
//               NZCV flags and gates execution on the condition code.
// Revision    : 1.0 - initial release
// ============================================================================
module armv4_mc_controller
    import armv4_pkg::*;
#(
    parameter int ALU_OPS       = 4,
    parameter int ALU_CTRL_W    = $clog2(ALU_OPS),
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [19:0]           instr,
    input  logic [3:0]            alu_flags,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            imm_src,
    output logic [1:0]            reg_src,
    output logic [1:0]            result_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [3:0]            state_o
);

    // instr carries Instr[31:12], so every field sits 12 bits lower.
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic       w_i;
    logic [3:0] w_cmd;
    logic       w_s;
    logic [3:0] w_rd;

    assign w_cond = instr[19:16];
    assign w_op   = instr[15:14];
    assign w_i    = instr[13];
    assign w_cmd  = instr[12:9];
    assign w_s    = instr[8];
    assign w_rd   = instr[3:0];

    state_t     r_state, w_next;
    logic [3:0] r_flags;
    logic       w_cond_ex;
    logic       w_ready;

    logic [2:0] w_dp_op;
    logic [2:0] w_alu_sel;
    logic       w_supported;
    logic       w_no_write;
    logic       w_logical;
    logic       w_flag_upd;
    logic       w_unused;

    // Without the handshake every memory access completes in one cycle.
    if (MEM_HANDSHAKE != 0) begin : g_handshake
        assign w_ready = mem_ready;
    end else begin : g_no_handshake
        assign w_ready = 1'b1;
    end

    // Rn is decoded by the datapath, not here.
    assign w_unused = ^{instr[7:4], w_alu_sel};

    armv4_cond_check u_cond_check (
        .cond    (w_cond),
        .flags   (r_flags),
        .cond_ex (w_cond_ex)
    );

    // Map the cmd field to an ALU op; unknown cmds become no-ops.
    always_comb begin
        w_dp_op     = ALU_ADD;
        w_supported = 1'b0;
        w_no_write  = 1'b0;
        w_logical   = 1'b0;
        case (w_cmd)
            CMD_ADD: begin w_dp_op = ALU_ADD; w_supported = 1'b1; end
            CMD_SUB: begin w_dp_op = ALU_SUB; w_supported = 1'b1; end
            CMD_CMP: begin w_dp_op = ALU_SUB; w_supported = 1'b1; w_no_write = 1'b1; end
            CMD_AND: begin w_dp_op = ALU_AND; w_supported = 1'b1; w_logical = 1'b1; end
            CMD_ORR: begin w_dp_op = ALU_ORR; w_supported = 1'b1; w_logical = 1'b1; end
            CMD_EOR: if (ALU_OPS == 8) begin w_dp_op = ALU_EOR; w_supported = 1'b1; w_logical = 1'b1; end
            CMD_MOV: if (ALU_OPS == 8) begin w_dp_op = ALU_MOV; w_supported = 1'b1; w_logical = 1'b1; end
            CMD_BIC: if (ALU_OPS == 8) begin w_dp_op = ALU_BIC; w_supported = 1'b1; w_logical = 1'b1; end
            default: ;
        endcase
    end

    assign w_flag_upd = ((r_state == ST_EXECR) || (r_state == ST_EXECI)) && w_s && w_supported;

    // Flags capture the ALU result at the end of an S-suffixed execute cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flags <= 4'b0000;
        end else if (w_flag_upd) begin
            if (w_logical) begin
                r_flags[FLAG_N] <= alu_flags[FLAG_N];
                r_flags[FLAG_Z] <= alu_flags[FLAG_Z];
            end else begin
                r_flags <= alu_flags;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs; strobes are forced low during reset.
    always_comb begin
        w_next      = ST_FETCH;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        imm_src     = 2'b00;
        reg_src     = 2'b00;
        result_src  = 2'b00;
        w_alu_sel   = ALU_ADD;
        case (r_state)
            ST_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (w_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = ST_DECODE;
                end else begin
                    w_next   = ST_FETCH;
                end
            end
            ST_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                reg_src[0] = (w_op == OP_BR);
                reg_src[1] = (w_op == OP_MEM);
                if (w_cond_ex) begin
                    case (w_op)
                        OP_DP:   w_next = w_i ? ST_EXECI : ST_EXECR;
                        OP_MEM:  w_next = ST_MEMADR;
                        OP_BR:   w_next = ST_BRANCH;
                        default: w_next = ST_FETCH;
                    endcase
                end
            end
            ST_EXECR: begin
                alu_src_b = 2'b00;
                w_alu_sel = w_dp_op;
                w_next    = ST_ALUWB;
            end
            ST_EXECI: begin
                alu_src_b = 2'b01;
                imm_src   = 2'b00;
                w_alu_sel = w_dp_op;
                w_next    = ST_ALUWB;
            end
            ST_ALUWB: begin
                result_src = 2'b00;
                reg_write  = w_supported & ~w_no_write;
                pc_write   = w_supported & ~w_no_write & (w_rd == 4'hF);
            end
            ST_MEMADR: begin
                alu_src_b = 2'b01;
                imm_src   = 2'b01;
                w_next    = w_s ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                w_next  = w_ready ? ST_MEMWB : ST_MEMRD;
            end
            ST_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                pc_write   = (w_rd == 4'hF);
            end
            ST_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                w_next    = w_ready ? ST_FETCH : ST_MEMWR;
            end
            ST_BRANCH: begin
                alu_src_a  = 1'b0;
                alu_src_b  = 2'b01;
                imm_src    = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            default: w_next = ST_FETCH;
        endcase
        if (!rst) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign alu_control = w_alu_sel[ALU_CTRL_W-1:0];
    assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_armv4_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_armv4_mc_controller
// Description : Directed self-checking bench for armv4_mc_controller. Two
//               instances (8-op and 4-op ALU) share one instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_armv4_mc_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] instr = 20'hF0000;
    logic [3:0]  alu_flags = 4'b0000;
    logic        mem_ready = 1'b1;

    logic       mem_req8, mem_write8, adr_src8, ir_write8, pc_write8, reg_write8, alu_src_a8;
    logic [1:0] alu_src_b8, imm_src8, reg_src8, result_src8;
    logic [2:0] alu_control8;
    logic [3:0] state8;

    logic       mem_req4, mem_write4, adr_src4, ir_write4, pc_write4, reg_write4, alu_src_a4;
    logic [1:0] alu_src_b4, imm_src4, reg_src4, result_src4;
    logic [1:0] alu_control4;
    logic [3:0] state4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    armv4_mc_controller #(.ALU_OPS(8), .MEM_HANDSHAKE(1)) u_dut8 (
        .clk(clk), .rst(rst), .instr(instr), .alu_flags(alu_flags), .mem_ready(mem_ready),
        .mem_req(mem_req8), .mem_write(mem_write8), .adr_src(adr_src8), .ir_write(ir_write8),
        .pc_write(pc_write8), .reg_write(reg_write8), .alu_src_a(alu_src_a8),
        .alu_src_b(alu_src_b8), .imm_src(imm_src8), .reg_src(reg_src8),
        .result_src(result_src8), .alu_control(alu_control8), .state_o(state8)
    );

    armv4_mc_controller #(.ALU_OPS(4), .MEM_HANDSHAKE(1)) u_dut4 (
        .clk(clk), .rst(rst), .instr(instr), .alu_flags(alu_flags), .mem_ready(mem_ready),
        .mem_req(mem_req4), .mem_write(mem_write4), .adr_src(adr_src4), .ir_write(ir_write4),
        .pc_write(pc_write4), .reg_write(reg_write4), .alu_src_a(alu_src_a4),
        .alu_src_b(alu_src_b4), .imm_src(imm_src4), .reg_src(reg_src4),
        .result_src(result_src4), .alu_control(alu_control4), .state_o(state4)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle and check both instances reached the same state.
    task automatic step_state(input string tag, input int exp);
        step();
        check_val({tag, "_st8"}, int'(state8), exp);
        check_val({tag, "_st4"}, int'(state4), exp);
    endtask

    initial begin
        // Reset held from time 0
        step();
        step();
        check_val("rst_state", int'(state8), 0);
        check_val("rst_mem_req", int'(mem_req8), 0);
        check_val("rst_ir_write", int'(ir_write8), 0);
        check_val("rst_pc_write", int'(pc_write8), 0);
        rst = 1'b1;
        #1;
        check_val("rel_mem_req", int'(mem_req8), 1);
        check_val("rel_ir_write", int'(ir_write8), 1);

        // ADD R1,R1,R2
        instr = 20'hE0811;
        check_val("add_fetch_rw", int'(reg_write8), 0);
        step_state("add_dec", 1);
        step_state("add_exe", 6);
        check_val("add_aluctl", int'(alu_control8), 0);
        check_val("add_exe_rw", int'(reg_write8), 0);
        step_state("add_wb", 8);
        check_val("add_wb_rw", int'(reg_write8), 1);
        check_val("add_wb_pcw", int'(pc_write8), 0);
        step_state("add_end", 0);

        // CMP with Z from the ALU, then BEQ taken
        instr = 20'hE1510;
        alu_flags = 4'b0100;
        step_state("cmp_dec", 1);
        step_state("cmp_exe", 6);
        check_val("cmp_aluctl", int'(alu_control8), 1);
        step_state("cmp_wb", 8);
        check_val("cmp_wb_rw", int'(reg_write8), 0);
        step_state("cmp_end", 0);
        alu_flags = 4'b0000;
        instr = 20'h0A000;
        step_state("beq_dec", 1);
        check_val("beq_regsrc", int'(reg_src8), 1);
        step_state("beq_br", 9);
        check_val("beq_pcw", int'(pc_write8), 1);
        check_val("beq_imm", int'(imm_src8), 2);
        check_val("beq_srca", int'(alu_src_a8), 0);
        step_state("beq_end", 0);

        // CMP clearing Z, then BEQ not taken
        instr = 20'hE1510;
        step_state("cmp0_dec", 1);
        step_state("cmp0_exe", 6);
        step_state("cmp0_wb", 8);
        step_state("cmp0_end", 0);
        instr = 20'h0A000;
        step_state("beqn_dec", 1);
        step_state("beqn_end", 0);

        // NV condition never executes
        instr = 20'hF0811;
        step_state("nv_dec", 1);
        step_state("nv_end", 0);

        // Set Z again, then reset in the middle of a stalled store
        instr = 20'hE1510;
        alu_flags = 4'b0100;
        step_state("cmpz_dec", 1);
        step_state("cmpz_exe", 6);
        step_state("cmpz_wb", 8);
        step_state("cmpz_end", 0);
        alu_flags = 4'b0000;
        instr = 20'hE5803;
        step_state("rstr_dec", 1);
        step_state("rstr_adr", 2);
        mem_ready = 1'b0;
        step_state("rstr_wr", 5);
        check_val("rstr_mw", int'(mem_write8), 1);
        rst = 1'b0;
        step_state("mid_rst1", 0);
        check_val("mid_rst1_mw", int'(mem_write8), 0);
        step_state("mid_rst2", 0);
        check_val("mid_rst2_mw", int'(mem_write8), 0);
        check_val("mid_rst2_mreq", int'(mem_req8), 0);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_val("post_rst_mreq", int'(mem_req8), 1);
        // Flags were cleared, so BEQ must fail
        instr = 20'h0A000;
        step_state("beqr_dec", 1);
        step_state("beqr_end", 0);

        // LDR with three wait cycles
        instr = 20'hE5903;
        step_state("ldr_dec", 1);
        step_state("ldr_adr", 2);
        mem_ready = 1'b0;
        step_state("ldr_rd1", 3);
        check_val("ldr_rd1_mreq", int'(mem_req8), 1);
        check_val("ldr_rd1_adr", int'(adr_src8), 1);
        step_state("ldr_rd2", 3);
        step_state("ldr_rd3", 3);
        step_state("ldr_rd4", 3);
        mem_ready = 1'b1;
        step_state("ldr_wb", 4);
        check_val("ldr_wb_rw", int'(reg_write8), 1);
        check_val("ldr_wb_rsrc", int'(result_src8), 1);
        check_val("ldr_wb_pcw", int'(pc_write8), 0);
        step_state("ldr_end", 0);

        // STR with two wait cycles
        instr = 20'hE5803;
        step_state("str_dec", 1);
        step_state("str_adr", 2);
        check_val("str_adr_rw", int'(reg_write8), 0);
        mem_ready = 1'b0;
        step_state("str_wr1", 5);
        check_val("str_wr1_mw", int'(mem_write8), 1);
        check_val("str_wr1_rw", int'(reg_write8), 0);
        step_state("str_wr2", 5);
        check_val("str_wr2_mw", int'(mem_write8), 1);
        step_state("str_wr3", 5);
        check_val("str_wr3_mw", int'(mem_write8), 1);
        check_val("str_wr3_rw", int'(reg_write8), 0);
        mem_ready = 1'b1;
        step_state("str_end", 0);
        check_val("str_end_mw", int'(mem_write8), 0);

        // EOR: real op on the 8-op ALU, no-op on the 4-op ALU
        instr = 20'hE0211;
        step_state("eor_dec", 1);
        step_state("eor_exe", 6);
        check_val("eor_aluctl8", int'(alu_control8), 4);
        step_state("eor_wb", 8);
        check_val("eor_wb_rw8", int'(reg_write8), 1);
        check_val("eor_wb_rw4", int'(reg_write4), 0);
        step_state("eor_end", 0);

        // EORS with Z: only the 8-op instance may update flags
        instr = 20'hE0311;
        alu_flags = 4'b0100;
        step_state("eors_dec", 1);
        step_state("eors_exe", 6);
        step_state("eors_wb", 8);
        step_state("eors_end", 0);
        alu_flags = 4'b0000;
        instr = 20'h0A000;
        step_state("beqe_dec", 1);
        step();
        check_val("beqe_st8", int'(state8), 9);
        check_val("beqe_st4", int'(state4), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/armv4_mc_controller.md
Name: armv4_mc_controller

Overview:
Multicycle control unit for the ARMv4-subset core used in the histogram-equalization processor. It is the successor to the single-cycle controller and drives a shared instruction/data memory datapath through a Moore FSM. It holds the NZCV flags register and evaluates condition codes. It is parametrised in ALU operation count and supports an optional wait-state memory handshake.

Parameters:
ALU_OPS, 4, number of ALU operations decoded; legal values are 4 (ADD/SUB/AND/ORR) or 8 (adds EOR/MOV/BIC).
ALU_CTRL_W, $clog2(ALU_OPS), width of alu_control.
MEM_HANDSHAKE, 1, 1 means memory states wait for mem_ready; 0 means mem_ready is ignored and treated as 1.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
instr  in  20  Instr[31:12]: cond, op, funct, Rd
alu_flags  in  4  NZCV from ALU, current cycle
mem_ready  in  1  memory access completes this cycle
mem_req  out  1  memory access active
mem_write  out  1  store strobe
adr_src  out  1  0=PC, 1=ALU result register
ir_write  out  1  load instruction register
pc_write  out  1  load PC
reg_write  out  1  register file write
alu_src_a  out  1  0=RD1, 1=PC
alu_src_b  out  2  00=RD2, 01=ExtImm, 10=constant 4
imm_src  out  2  00=imm8 rot, 01=imm12, 10=imm24 branch
reg_src  out  2  [0] RA1 reads R15; [1] RA2 reads Rd
result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
alu_control  out  ALU_CTRL_W  ALU op select
state_o  out  4  current state, debug only

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10-15 are illegal and go to FETCH on the next cycle with all strobes 0.
- Reset: while rst==0, every strobe (mem_req, mem_write, ir_write, pc_write, reg_write) is 0. State loads FETCH and flags load 0000 on that edge.
- Field decode: op=instr[27:26]; I=instr[25]; cmd=instr[24:21]; S/L=instr[20]; Rd=instr[15:12].
- FETCH: mem_req=1, adr_src=0, alu_src_a=1, alu_src_b=10, ADD, result_src=10.
  - ir_write and pc_write are 1 only when mem_ready (or MEM_HANDSHAKE=0). In that case go to DECODE; otherwise stay in FETCH.
- DECODE: alu_src_a=1, alu_src_b=10, reg_src[0]=(op==10), reg_src[1]=(op==01).
  - If cond_ex==0, go to FETCH.
  - Otherwise: op 00 goes to EXECI if I, else EXECR. Op 01 goes to MEMADR. Op 10 goes to BRANCH. Op 11 goes to FETCH (NOP).
- EXECR / EXECI: alu_src_b=00 (EXECR) or 01 with imm_src=00 (EXECI); alu_control decoded from cmd. Next state is ALUWB.
  - Flag update happens at the end of this cycle when S=1 and cmd is supported: ADD/SUB/CMP write NZCV; logical ops write NZ and keep CV.
- ALU decode: ADD 0100→0; SUB 0010→1; AND 0000→2; ORR 1100→3; CMP 1010→1 with no_write.
  - With ALU_OPS=8 also: EOR 0001→4, MOV 1101→5, BIC 1110→6.
  - Any other cmd is a NOP: no reg_write and no flag update.
- ALUWB: result_src=00, reg_write=~no_write. pc_write=1 when Rd==15 and the write is enabled. Next state is FETCH.
- MEMADR: alu_src_b=01, imm_src=01, ADD. Next state is MEMRD if L, else MEMWR.
- MEMRD: mem_req=1, adr_src=1. Stay until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, pc_write=(Rd==15). Next state is FETCH.
- MEMWR: mem_req=1, mem_write=1, adr_src=1. Both are held every cycle until mem_ready, then go to FETCH.
- BRANCH: alu_src_a=0, alu_src_b=01, imm_src=10, ADD, result_src=10, pc_write=1. Next state is FETCH.
- Condition check: cond codes 0000-1110 are evaluated per ARMv4 against the registered flags. Code 1111 evaluates false.
- Latency in cycles with zero wait states: data-processing 4, LDR 5, STR 4, taken branch 3, condition-failed instruction 2.

Decomposition:
- Package armv4_pkg holds:
  - the state enum;
  - the ALU op constants (ALU_ADD..ALU_BIC);
  - the op and cmd field constants;
  - the flag bit indices.
- Sub-module armv4_cond_check: combinational; inputs cond[3:0] and flags[3:0], output cond_ex.

Test Plan:
- Reset: hold rst=0 for 2 cycles mid-MEMWR → state_o=0, flags=0, mem_write=0; first cycle after release is FETCH.
- E0811002 (ADD R1,R1,R2), mem_ready=1 → states 0,1,6,8,0; alu_control=0 in EXECR; reg_write=1 only in ALUWB.
- E1510002 (CMP) with alu_flags=0100 → flags Z=1, no reg_write. Then 0A000002 (BEQ) → 0,1,9 with pc_write=1 and imm_src=10. With Z=0 instead → 0,1,0.
- E5903004 (LDR) with mem_ready low for 3 cycles in MEMRD → MEMRD held 4 cycles, then MEMWB with reg_write=1 and result_src=01.
- E5803004 (STR) with mem_ready low for 2 cycles → mem_write=1 for 3 consecutive cycles, then FETCH; reg_write never asserted.
- E0211002 (EOR): ALU_OPS=8 → alu_control=4 and reg_write in ALUWB. ALU_OPS=4 → NOP with no reg_write and flags unchanged.
